// File: rtl/hs_pipe_slice_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hs_pkg
// Brief   : Shared slice-mode constants and occupancy sizing for hs_pipe_slice.
// Revision: 1.0 - initial release
// ============================================================================
package hs_pkg;

    localparam int HS_MODE_BYPASS = 0;
    localparam int HS_MODE_FWD    = 1;
    localparam int HS_MODE_BWD    = 2;
    localparam int HS_MODE_FULL   = 3;

    // Per-stage held-beat count (0..2).
    typedef logic [1:0] hs_occ_t;

    function automatic int hs_occ_w(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_pipe_slice_stage.sv
`default_nettype none
// ============================================================================
// Module  : hs_slice_stage
// Brief   : One valid/ready register slice stage (bypass, fwd, bwd/skid, full).
// Revision: 1.0 - initial release
// ============================================================================
module hs_slice_stage
    import hs_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int MODE   = HS_MODE_FULL
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              valid_up,
    input  logic [DATA_W-1:0] data_up,
    output logic              ready_up,
    output logic              valid_down,
    output logic [DATA_W-1:0] data_down,
    input  logic              ready_down,
    output hs_occ_t           occ
);

    generate
        if (MODE == HS_MODE_FWD) begin : g_fwd
            logic              v;
            logic [DATA_W-1:0] data_q;

            assign ready_up = !v || ready_down;

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    v      <= 1'b0;
                    data_q <= '0;
                end else if (valid_up && ready_up) begin
                    v      <= 1'b1;
                    data_q <= data_up;
                end else if (ready_down) begin
                    v      <= 1'b0;
                end
            end

            assign valid_down = v;
            assign data_down  = data_q;
            assign occ        = {1'b0, v};
        end else if (MODE == HS_MODE_BWD) begin : g_bwd
            logic              skid_v;
            logic [DATA_W-1:0] skid_data;

            // Ready comes straight from a flop, cutting the backward path.
            assign ready_up   = !skid_v;
            assign valid_down = valid_up || skid_v;
            assign data_down  = skid_v ? skid_data : data_up;

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    skid_v    <= 1'b0;
                    skid_data <= '0;
                end else if (ready_down) begin
                    skid_v    <= 1'b0;
                end else if (valid_up && !skid_v) begin
                    skid_v    <= 1'b1;
                    skid_data <= data_up;
                end
            end

            assign occ = {1'b0, skid_v};
        end else if (MODE == HS_MODE_FULL) begin : g_full
            // State bits are {main_v, skid_v}.
            localparam logic [1:0] ST_EMPTY = 2'b00;
            localparam logic [1:0] ST_ONE   = 2'b10;
            localparam logic [1:0] ST_TWO   = 2'b11;

            logic [1:0]        state;
            logic [DATA_W-1:0] main_q;
            logic [DATA_W-1:0] skid_q;
            logic              take_in;
            logic              take_out;

            assign ready_up = !state[0];
            assign take_in  = valid_up && ready_up;
            assign take_out = state[1] && ready_down;

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    state  <= ST_EMPTY;
                    main_q <= '0;
                    skid_q <= '0;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (take_in) begin
                                state  <= ST_ONE;
                                main_q <= data_up;
                            end
                        end
                        ST_ONE: begin
                            if (take_in && take_out) begin
                                main_q <= data_up;
                            end else if (take_in) begin
                                state  <= ST_TWO;
                                skid_q <= data_up;
                            end else if (take_out) begin
                                state  <= ST_EMPTY;
                            end
                        end
                        ST_TWO: begin
                            if (take_out) begin
                                state  <= ST_ONE;
                                main_q <= skid_q;
                            end
                        end
                        default: begin
                            state <= ST_EMPTY;
                        end
                    endcase
                end
            end

            assign valid_down = state[1];
            assign data_down  = main_q;
            assign occ        = state[0] ? 2'd2 : {1'b0, state[1]};
        end else begin : g_bypass
            logic unused_clk_rst;

            assign unused_clk_rst = sys_clk ^ sys_rst_n;
            assign valid_down     = valid_up;
            assign data_down      = data_up;
            assign ready_up       = ready_down;
            assign occ            = 2'd0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/hs_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module  : hs_pipe_slice
// Brief   : Parametrised chain of valid/ready slice stages with occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
module hs_pipe_slice
    import hs_pkg::*;
#(
    parameter int DATA_W = 3,
    parameter int STAGES = 1,
    parameter int MODE   = HS_MODE_FULL
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          valid_up,
    input  logic [DATA_W-1:0]             data_up,
    output logic                          ready_up,
    output logic                          valid_down,
    output logic [DATA_W-1:0]             data_down,
    input  logic                          ready_down,
    output logic [hs_occ_w(STAGES)-1:0]   occupancy
);

    localparam int OCC_W = hs_occ_w(STAGES);

    generate
        if (MODE == HS_MODE_BYPASS) begin : g_bypass
            logic unused_clk_rst;

            assign unused_clk_rst = sys_clk ^ sys_rst_n;
            assign valid_down     = valid_up;
            assign data_down      = data_up;
            assign ready_up       = ready_down;
            assign occupancy      = '0;
        end else begin : g_chain
            // Index k is the upstream side of stage k; index STAGES is the output.
            logic [STAGES:0]   valid_c;
            logic [STAGES:0]   ready_c;
            logic [DATA_W-1:0] data_c [STAGES+1];
            hs_occ_t           occ_c  [STAGES];
            logic [OCC_W-1:0]  occ_sum;

            assign valid_c[0]       = valid_up;
            assign data_c[0]        = data_up;
            assign ready_up         = ready_c[0];
            assign valid_down       = valid_c[STAGES];
            assign data_down        = data_c[STAGES];
            assign ready_c[STAGES]  = ready_down;

            for (genvar k = 0; k < STAGES; k++) begin : g_stage
                hs_slice_stage #(
                    .DATA_W (DATA_W),
                    .MODE   (MODE)
                ) u_stage (
                    .sys_clk    (sys_clk),
                    .sys_rst_n  (sys_rst_n),
                    .valid_up   (valid_c[k]),
                    .data_up    (data_c[k]),
                    .ready_up   (ready_c[k]),
                    .valid_down (valid_c[k+1]),
                    .data_down  (data_c[k+1]),
                    .ready_down (ready_c[k+1]),
                    .occ        (occ_c[k])
                );
            end

            always_comb begin
                occ_sum = '0;
                for (int k = 0; k < STAGES; k++) begin
                    occ_sum = occ_sum + OCC_W'(occ_c[k]);
                end
            end

            assign occupancy = occ_sum;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_hs_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module  : tb_hs_pipe_slice
// Brief   : Scoreboard bench driving several slice configurations side by side.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hs_pipe_slice;

    localparam int N = 7;

    function automatic int md_of(input int g);
        case (g)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 3;
            5: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int st_of(input int g);
        case (g)
            1: return 4;
            2: return 2;
            4: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int dw_of(input int g);
        case (g)
            1: return 8;
            4: return 8;
            5: return 8;
            6: return 5;
            default: return 3;
        endcase
    endfunction

    function automatic int cap_of(input int g);
        if (md_of(g) == 0) return 0;
        if (md_of(g) == 3) return 2 * st_of(g);
        return st_of(g);
    endfunction

    function automatic bit lat0(input int g);
        return (md_of(g) == 0) || (md_of(g) == 2);
    endfunction

    function automatic int msk(input int g);
        return (1 << dw_of(g)) - 1;
    endfunction

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   vup;
    logic [N-1:0]   rdn;
    logic [7:0]     dup [N];
    wire  [N-1:0]   rup;
    wire  [N-1:0]   vdn;
    wire  [7:0]     ddn [N];
    wire  [7:0]     occ [N];

    int errors = 0;
    int checks = 0;

    // Scoreboard: beats accepted upstream and not yet delivered, per DUT.
    logic [7:0]     fb [N][64];
    int             hd [N];
    int             tl [N];
    logic [N-1:0]   xu;
    logic [N-1:0]   stall;
    logic [7:0]     hold_d [N];

    int pvt [4] = '{90, 50, 95, 30};
    int prt [4] = '{90, 30, 10, 95};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int W  = dw_of(g);
        localparam int OW = hs_pkg::hs_occ_w(st_of(g));
        logic [W-1:0]  du;
        wire  [W-1:0]  dd;
        wire  [OW-1:0] oc;

        assign du     = dup[g][W-1:0];
        assign ddn[g] = 8'(dd);
        assign occ[g] = 8'(oc);

        hs_pipe_slice #(
            .DATA_W (W),
            .STAGES (st_of(g)),
            .MODE   (md_of(g))
        ) u_dut (
            .sys_clk    (clk),
            .sys_rst_n  (rst_n),
            .valid_up   (vup[g]),
            .data_up    (du),
            .ready_up   (rup[g]),
            .valid_down (vdn[g]),
            .data_down  (dd),
            .ready_down (rdn[g]),
            .occupancy  (oc)
        );
    end

    task automatic chk(input string nm, input int g, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", nm, g, $time, act, exp);
        end
    endtask

    // New beat only once the previous one was accepted (valid never withdrawn).
    task automatic drive_step(input int pv, input int pr);
        for (int g = 0; g < N; g++) begin
            if (!vup[g] || xu[g]) begin
                vup[g] = ($urandom_range(99) < pv);
                dup[g] = 8'($urandom & msk(g));
            end
            rdn[g] = ($urandom_range(99) < pr);
        end
    endtask

    initial begin : compare
        int sz;
        logic [7:0] exp_d;
        for (int g = 0; g < N; g++) begin
            hd[g] = 0; tl[g] = 0; hold_d[g] = '0;
        end
        xu = '0; stall = '0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                if (!rst_n) begin
                    hd[g] = 0; tl[g] = 0; xu[g] = 1'b0; stall[g] = 1'b0;
                    chk("rst_valid", g, int'(vdn[g]), 0);
                    chk("rst_occ", g, int'(occ[g]), 0);
                    chk("rst_ready", g, int'(rup[g]), (md_of(g) == 0) ? int'(rdn[g]) : 1);
                    chk("rst_data", g, int'(ddn[g]), lat0(g) ? int'(dup[g]) : 0);
                end else begin
                    sz = tl[g] - hd[g];
                    chk("occ", g, int'(occ[g]), sz);
                    chk("occ_cap", g, int'(int'(occ[g]) <= cap_of(g)), 1);
                    case (md_of(g))
                        0: chk("rdy_bypass", g, int'(rup[g]), int'(rdn[g]));
                        1: chk("rdy_fwd", g, int'(rup[g]), int'((sz < st_of(g)) || rdn[g]));
                        default: begin
                            if (st_of(g) == 1) chk("rdy_reg", g, int'(rup[g]), int'(sz < cap_of(g)));
                            else if (sz == 0) chk("rdy_empty", g, int'(rup[g]), 1);
                            else if (sz >= cap_of(g)) chk("rdy_full", g, int'(rup[g]), 0);
                        end
                    endcase
                    if (lat0(g)) chk("vld_comb", g, int'(vdn[g]), int'((sz > 0) || vup[g]));
                    else if (st_of(g) == 1) chk("vld_reg", g, int'(vdn[g]), int'(sz > 0));
                    else if (sz == 0) chk("vld_empty", g, int'(vdn[g]), 0);
                    if (md_of(g) == 0) chk("bypass_data", g, int'(ddn[g]), int'(dup[g]));
                    if (vdn[g]) begin
                        exp_d = (sz > 0) ? fb[g][hd[g] % 64] : dup[g];
                        chk("data", g, int'(ddn[g]), int'(exp_d));
                    end
                    if (stall[g]) begin
                        chk("hold_valid", g, int'(vdn[g]), 1);
                        chk("hold_data", g, int'(ddn[g]), int'(hold_d[g]));
                    end
                    xu[g] = vup[g] & rup[g];
                    if (xu[g]) begin
                        fb[g][tl[g] % 64] = dup[g];
                        tl[g]++;
                    end
                    if (vdn[g] && rdn[g] && (tl[g] != hd[g])) hd[g]++;
                    stall[g]  = vdn[g] & ~rdn[g];
                    hold_d[g] = ddn[g];
                end
            end
        end
    end

    initial begin : main
        int idx;
        int delivered;
        int maxocc;
        rst_n = 1'b0;
        vup = '0;
        rdn = '0;
        for (int g = 0; g < N; g++) dup[g] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Full mode, 1 stage: traffic, reset mid-stream, then a 4-beat burst.
        repeat (6) begin
            @(posedge clk); #1;
            drive_step(90, 50);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        vup = '0;
        @(negedge clk);
        chk("t1_rst_valid", 3, int'(vdn[3]), 0);
        chk("t1_rst_occ", 3, int'(occ[3]), 0);
        chk("t1_rst_ready", 3, int'(rup[3]), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        vup[3] = 1'b1; dup[3] = 8'd1; rdn[3] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (i < 4) dup[3] = 8'(i + 1);
            else vup[3] = 1'b0;
            @(negedge clk);
            chk("t1_valid", 3, int'(vdn[3]), 1);
            chk("t1_data", 3, int'(ddn[3]), i);
            chk("t1_occ", 3, int'(occ[3]), 1);
        end

        // Full mode stall: 5 and 6 fill main+skid, 7 is held off.
        @(posedge clk); #1;
        rdn[3] = 1'b0; vup[3] = 1'b1; dup[3] = 8'd5;
        @(posedge clk); #1;
        dup[3] = 8'd6;
        @(negedge clk);
        chk("t2_occ1", 3, int'(occ[3]), 1);
        chk("t2_data5", 3, int'(ddn[3]), 5);
        chk("t2_ready1", 3, int'(rup[3]), 1);
        @(posedge clk); #1;
        dup[3] = 8'd7;
        @(negedge clk);
        chk("t2_occ2", 3, int'(occ[3]), 2);
        chk("t2_ready0", 3, int'(rup[3]), 0);
        @(posedge clk); #1;
        rdn[3] = 1'b1;
        @(negedge clk);
        chk("t2_held_occ", 3, int'(occ[3]), 2);
        chk("t2_held_data", 3, int'(ddn[3]), 5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_data6", 3, int'(ddn[3]), 6);
        chk("t2_ready_again", 3, int'(rup[3]), 1);
        @(posedge clk); #1;
        vup[3] = 1'b0;
        @(negedge clk);
        chk("t2_data7", 3, int'(ddn[3]), 7);
        chk("t2_occ_one", 3, int'(occ[3]), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_empty_valid", 3, int'(vdn[3]), 0);
        chk("t2_empty_occ", 3, int'(occ[3]), 0);

        // Backward mode, 2 stages: beats 0..7 against toggling ready.
        idx = 0; delivered = 0; maxocc = 0;
        @(posedge clk); #1;
        vup[2] = 1'b1; dup[2] = 8'd0; rdn[2] = 1'b1;
        for (int c = 0; c < 40 && delivered < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("t3_lat0_valid", 2, int'(vdn[2]), 1);
                chk("t3_lat0_data", 2, int'(ddn[2]), 0);
            end
            if (vdn[2] && rdn[2]) delivered++;
            if (vup[2] && rup[2]) idx++;
            if (int'(occ[2]) > maxocc) maxocc = int'(occ[2]);
            @(posedge clk); #1;
            if (idx >= 8) vup[2] = 1'b0;
            else dup[2] = 8'(idx);
            rdn[2] = ~rdn[2];
        end
        chk("t3_delivered", 2, delivered, 8);
        chk("t3_max_occ", 2, int'(maxocc <= 2), 1);

        // Forward mode, 4 stages: 16-beat stream, 4-cycle latency.
        @(posedge clk); #1;
        rdn[1] = 1'b1; vup[1] = 1'b1; dup[1] = 8'h00;
        for (int m = 0; m < 22; m++) begin
            @(negedge clk);
            chk("t4_valid", 1, int'(vdn[1]), int'(m >= 4 && m < 20));
            if (m >= 4 && m < 20) chk("t4_data", 1, int'(ddn[1]), m - 4);
            if (m >= 4 && m <= 16) chk("t4_occ", 1, int'(occ[1]), 4);
            chk("t4_ready", 1, int'(rup[1]), 1);
            @(posedge clk); #1;
            if (m + 1 < 16) dup[1] = 8'(m + 1);
            else vup[1] = 1'b0;
        end

        // Random traffic on every configuration, with one reset mid-run.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk); #1;
            if (c == 3000) begin
                rst_n = 1'b0;
                vup = '0;
            end else if (c == 3002) begin
                rst_n = 1'b1;
            end
            if (rst_n) drive_step(pvt[c / 2500], prt[c / 2500]);
        end

        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            drive_step(0, 100);
        end
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk("drain_model_empty", g, tl[g] - hd[g], 0);
            chk("drain_occ", g, int'(occ[g]), 0);
            chk("drain_valid", g, int'(vdn[g]), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
